mem_map_arbiter: RTL

MEM_MAP_ARBITER -- requirements
Module: mem_map_arbiter

---
 rtl/mem_map_arbiter_pkg.sv | 20 ++
 rtl/mem_map_arbiter_if.sv | 30 +++
 rtl/mem_map_arbiter_rr.sv | 28 ++
 rtl/mem_map_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_map_arbiter_pkg.sv
// mem_map_pkg: shared constants and types for the memory-map arbiter.
//   - default region base / size vectors (index 0 in the LSBs)
//   - register-file base and register index constants
//   - target-select enum used by the decoder and the read-data mux
package mem_map_pkg;

  localparam int unsigned LOG2_W = 8;  // width of each RGN_LOG2 entry

  // Region 0 is 16'h4400 (1K words), region 1 is 16'h2400 (8K words),
  // region 2 is 16'h2000 (1K words) and region 3 is 16'h0000 (8K words).
  localparam logic [63:0] RGN_BASE_DEF = {16'h0000, 16'h2000, 16'h2400, 16'h4400};
  localparam logic [31:0] RGN_LOG2_DEF = {8'd13, 8'd10, 8'd13, 8'd10};

  localparam logic [15:0] REG_BASE_DEF = 16'h4800;
  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned REG_IDX_W    = 4;

  typedef enum logic [1:0] {RGN, REG, NONE} tgt_e;

endpackage

// File: rtl/mem_map_arbiter_if.sv
// mem_map_arbiter_if: request/grant/read-response bus of the two masters
// (m0 = CPU, m1 = DMA).
//   master modport: drives req/addr/we/wdata, receives gnt/rvalid/rdata
//   slave  modport: the arbiter side of the same signals
interface mem_map_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              m0_req,    m1_req;
  logic [ADDR_W-1:0] m0_addr,   m1_addr;
  logic              m0_we,     m1_we;
  logic [DATA_W-1:0] m0_wdata,  m1_wdata;
  logic              m0_gnt,    m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata,  m1_rdata;

  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    output m1_req, m1_addr, m1_we, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata
  );
endinterface

// File: rtl/mem_map_arbiter_rr.sv
// mem_map_rr_arbiter: two-master arbiter.
//   clk, rst  : clock, synchronous active-low reset
//   req[1:0]  : requests (bit 0 = m0, bit 1 = m1)
//   rr_en     : 0 = fixed priority to m0, 1 = round-robin on contention
//   gnt[1:0]  : combinational one-hot grant, forced to 0 while in reset
module mem_map_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  // Most recent contention winner; resets to m1 so m0 wins first.
  logic last_m1;

  always_comb begin
    gnt = '0;
    if (rst) begin
      if (req == 2'b11) gnt = (rr_en && !last_m1) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)               last_m1 <= 1'b1;
    else if (req == 2'b11)  last_m1 <= gnt[1];
  end
endmodule

// File: rtl/mem_map_arbiter.sv
// mem_map_arbiter: arbitrates CPU (m0) and DMA (m1) accesses onto external
// synchronous-RAM regions and an internal register file.
//   clk, rst   : clock, synchronous active-low reset
//   bus        : master request/grant/read-response bus (slave modport)
//   rgn_en     : one-hot region select in the grant cycle
//   rgn_addr   : region-relative offset; rgn_we/rgn_wdata write strobe/data
//   rgn_rdata  : per-region read data, one cycle after rgn_en
//   reg_out    : register contents (read-only registers show 0)
//   reg_in     : source values for read-only registers
//   reg_wstb   : per-register pulse the cycle after a write
//   bus_err    : pulse the cycle after an unmapped access
// Read latency is one cycle for every target.
module mem_map_arbiter
  import mem_map_pkg::*;
#(
  parameter int unsigned                  ADDR_W   = 16,
  parameter int unsigned                  DATA_W   = 16,
  parameter int unsigned                  NUM_RGN  = 4,
  parameter logic [NUM_RGN*ADDR_W-1:0]    RGN_BASE = RGN_BASE_DEF,
  parameter logic [NUM_RGN*LOG2_W-1:0]    RGN_LOG2 = RGN_LOG2_DEF,
  parameter logic [ADDR_W-1:0]            REG_BASE = REG_BASE_DEF,
  parameter int unsigned                  NUM_REGS = NUM_REGS_DEF,
  parameter logic [NUM_REGS-1:0]          RO_MASK  = '0,
  parameter bit                           RR_EN    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_map_arbiter_if.slave             bus,
  output logic [NUM_RGN-1:0]           rgn_en,
  output logic [ADDR_W-1:0]            rgn_addr,
  output logic                         rgn_we,
  output logic [DATA_W-1:0]            rgn_wdata,
  input  logic [NUM_RGN*DATA_W-1:0]    rgn_rdata,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
  output logic [NUM_REGS-1:0]          reg_wstb,
  output logic                         bus_err
);
  localparam int unsigned RIDX_W = (NUM_RGN  > 1) ? $clog2(NUM_RGN)  : 1;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [1:0]        gnt;
  logic              acc, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  tgt_e              tgt, tgt_q;
  logic [RIDX_W-1:0] rgn_idx, rgn_idx_q;
  logic [ADDR_W-1:0] rgn_off, reg_off;
  logic [IDX_W-1:0]  reg_idx;
  logic [DATA_W-1:0] reg_rd, reg_rd_q, rd_mux;
  logic              rv_m0, rv_m1;
  logic [DATA_W-1:0] regs [NUM_REGS];

  mem_map_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({bus.m1_req, bus.m0_req}),
    .rr_en (RR_EN),
    .gnt   (gnt)
  );

  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];
  assign acc        = |gnt;
  assign sel_addr   = gnt[1] ? bus.m1_addr  : bus.m0_addr;
  assign sel_we     = gnt[1] ? bus.m1_we    : bus.m0_we;
  assign sel_wdata  = gnt[1] ? bus.m1_wdata : bus.m0_wdata;

  // Regions are scanned from the highest index down so the lowest hitting
  // index is the one left standing; registers only decode on a region miss.
  always_comb begin
    logic [ADDR_W-1:0] off;
    off     = '0;
    tgt     = NONE;
    rgn_idx = '0;
    rgn_off = '0;
    for (int unsigned i = NUM_RGN; i > 0; i--) begin
      off = sel_addr - RGN_BASE[(i-1)*ADDR_W +: ADDR_W];
      if ((off >> RGN_LOG2[(i-1)*LOG2_W +: LOG2_W]) == '0) begin
        tgt     = RGN;
        rgn_idx = RIDX_W'(i-1);
        rgn_off = off;
      end
    end
    reg_off = sel_addr - REG_BASE;
    reg_idx = reg_off[IDX_W-1:0];
    if (tgt != RGN && reg_off < ADDR_W'(NUM_REGS)) tgt = REG;
  end

  assign reg_rd = RO_MASK[reg_idx] ? reg_in[int'(reg_idx)*DATA_W +: DATA_W]
                                   : regs[reg_idx];

  always_comb begin
    rgn_en   = '0;
    rgn_addr = '0;
    if (acc && tgt == RGN) begin
      rgn_en   = NUM_RGN'(1) << rgn_idx;
      rgn_addr = rgn_off;
    end
  end
  assign rgn_we    = acc && sel_we && (tgt == RGN);
  assign rgn_wdata = sel_wdata;

  // Register read data is captured in the grant cycle, before any write of
  // that same edge lands, giving read-before-write behaviour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wstb  <= '0;
      rv_m0     <= 1'b0;
      rv_m1     <= 1'b0;
      bus_err   <= 1'b0;
      tgt_q     <= NONE;
      rgn_idx_q <= '0;
      reg_rd_q  <= '0;
    end else begin
      rv_m0     <= gnt[0] && !bus.m0_we;
      rv_m1     <= gnt[1] && !bus.m1_we;
      bus_err   <= acc && (tgt == NONE);
      tgt_q     <= tgt;
      rgn_idx_q <= rgn_idx;
      reg_rd_q  <= reg_rd;
      reg_wstb  <= '0;
      if (acc && sel_we && tgt == REG) begin
        reg_wstb[reg_idx] <= 1'b1;
        if (!RO_MASK[reg_idx]) regs[reg_idx] <= sel_wdata;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (tgt_q)
      RGN:     rd_mux = rgn_rdata[int'(rgn_idx_q)*DATA_W +: DATA_W];
      REG:     rd_mux = reg_rd_q;
      default: rd_mux = '0;
    endcase
  end

  assign bus.m0_rvalid = rv_m0;
  assign bus.m1_rvalid = rv_m1;
  assign bus.m0_rdata  = rv_m0 ? rd_mux : '0;
  assign bus.m1_rdata  = rv_m1 ? rd_mux : '0;

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      reg_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs[i];
  end
endmodule
